// File: rtl/vline_pkg.sv
// Shared types and constants for the vertical-line motion sequencer.
// The STEP2 state is only reachable when VLINE_ACCEL_EN is defined.
package vline_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_STEP2
  } vline_state_e;

  localparam int unsigned VLINE_TOP_LIMIT = 487;
  localparam int unsigned VLINE_BOT_LIMIT = 18;
  localparam int unsigned VLINE_START_POS = 240;

  // Unsigned clamp of a coordinate into [lo, hi]
  function automatic logic [31:0] vline_clamp(input logic [31:0] v,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/vline_motion_ctrl_if.sv
// Request/strobe bundle between button logic, line counter and the sequencer.
// master drives requests and the counter value; slave is the sequencer.
interface vline_motion_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             frame_tick;
  logic             btn_up;
  logic             btn_dw;
  logic             auto_en;
  logic             load_req;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] ycoord;
  logic             UP;
  logic             DW;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic             dir_up;
  logic             busy;

  modport master (
    output frame_tick, btn_up, btn_dw, auto_en, load_req, load_val, ycoord,
    input  UP, DW, LD, D, dir_up, busy
  );

  modport slave (
    input  frame_tick, btn_up, btn_dw, auto_en, load_req, load_val, ycoord,
    output UP, DW, LD, D, dir_up, busy
  );
endinterface

// File: rtl/vline_step_timer.sv
// Frame-tick divider: pulses qual_tick_c_o on every STEP_DIV-th frame tick.
// The pulse is combinational so it lines up with the frame tick itself.
module vline_step_timer #(
  parameter int unsigned STEP_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick_i,
  output logic qual_tick_c_o
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             wrap_c;

  assign wrap_c        = (32'(cnt_q) == (STEP_DIV - 1));
  assign qual_tick_c_o = frame_tick_i && wrap_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (frame_tick_i) begin
      cnt_q <= wrap_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vline_motion_ctrl.sv
// Sequencer turning buttons, auto-bounce and load requests into UP/DW/LD strobes.
// Optional VLINE_ACCEL_EN: held manual steps double up after ACCEL_STEPS steps.
module vline_motion_ctrl
  import vline_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned TOP_LIMIT   = VLINE_TOP_LIMIT,
  parameter int unsigned BOT_LIMIT   = VLINE_BOT_LIMIT,
  parameter int unsigned START_POS   = VLINE_START_POS,
`ifdef VLINE_ACCEL_EN
  parameter int unsigned ACCEL_STEPS = 8,
`endif
  parameter int unsigned STEP_DIV    = 2
) (
  input  logic               clk,
  input  logic               reset,
  vline_motion_ctrl_if.slave bus
);

  vline_state_e     state_q;
  logic             up_q, dw_q, ld_q, dir_up_q, busy_q, pend_q;
  logic [WIDTH-1:0] d_q, pend_val_q;

  logic             qual_c, man_c, step_up_c, up_block_c, dw_block_c;
  logic [31:0]      y_c;
  logic [WIDTH-1:0] ld_src_c, ld_clamp_c;

  vline_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk           (clk),
    .reset         (reset),
    .frame_tick_i  (bus.frame_tick),
    .qual_tick_c_o (qual_c)
  );

  assign y_c        = 32'(bus.ycoord);
  assign man_c      = bus.btn_up ^ bus.btn_dw;
  assign step_up_c  = man_c ? bus.btn_up : dir_up_q;
  // Limits also cover out-of-range coordinates: only moves back toward range pass
  assign up_block_c = (y_c >= TOP_LIMIT);
  assign dw_block_c = (y_c <= BOT_LIMIT);
  // A fresh request wins over one latched while busy
  assign ld_src_c   = bus.load_req ? bus.load_val : pend_val_q;
  assign ld_clamp_c = WIDTH'(vline_clamp(32'(ld_src_c), 32'(BOT_LIMIT), 32'(TOP_LIMIT)));

`ifdef VLINE_ACCEL_EN
  localparam int unsigned ACC_W = $clog2(ACCEL_STEPS + 1);

  logic [ACC_W-1:0] acc_cnt_q;
  logic             acc_dir_q, dbl_q, step_up_q;
  logic             acc_same_c, up2_block_c, dw2_block_c;

  assign acc_same_c  = (acc_cnt_q != '0) && (acc_dir_q == bus.btn_up);
  // Counter has not yet absorbed the first strobe, so account for it here
  assign up2_block_c = ((y_c + 32'(up_q)) >= TOP_LIMIT);
  assign dw2_block_c = (y_c <= (BOT_LIMIT + 32'(dw_q)));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      up_q       <= 1'b0;
      dw_q       <= 1'b0;
      ld_q       <= 1'b0;
      d_q        <= '0;
      dir_up_q   <= 1'b1;
      busy_q     <= 1'b1;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
`ifdef VLINE_ACCEL_EN
      acc_cnt_q  <= '0;
      acc_dir_q  <= 1'b0;
      dbl_q      <= 1'b0;
      step_up_q  <= 1'b0;
`endif
    end else begin
      up_q <= 1'b0;
      dw_q <= 1'b0;
      ld_q <= 1'b0;

      if ((state_q != S_IDLE) && bus.load_req) begin
        pend_q     <= 1'b1;
        pend_val_q <= bus.load_val;
      end
`ifdef VLINE_ACCEL_EN
      if (!man_c) acc_cnt_q <= '0;
`endif

      case (state_q)
        S_INIT: begin
          ld_q    <= 1'b1;
          d_q     <= WIDTH'(START_POS);
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        S_IDLE: begin
          if (bus.load_req || pend_q) begin
            state_q <= S_LOAD;
            ld_q    <= 1'b1;
            d_q     <= ld_clamp_c;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
`ifdef VLINE_ACCEL_EN
            acc_cnt_q <= '0;
`endif
          end else if (qual_c && (man_c || bus.auto_en)) begin
            state_q <= S_STEP;
            busy_q  <= 1'b1;
            up_q    <= step_up_c && !up_block_c;
            dw_q    <= !step_up_c && !dw_block_c;
            if (!man_c) begin
              if (step_up_c && (up_block_c || (y_c == TOP_LIMIT - 1))) dir_up_q <= 1'b0;
              if (!step_up_c && (dw_block_c || (y_c == BOT_LIMIT + 1))) dir_up_q <= 1'b1;
            end
`ifdef VLINE_ACCEL_EN
            step_up_q <= step_up_c;
            dbl_q     <= man_c && acc_same_c && (32'(acc_cnt_q) >= ACCEL_STEPS);
            if (man_c) begin
              acc_dir_q <= bus.btn_up;
              if (!acc_same_c) acc_cnt_q <= ACC_W'(1);
              else if (32'(acc_cnt_q) < ACCEL_STEPS) acc_cnt_q <= acc_cnt_q + ACC_W'(1);
            end
`endif
          end
        end

        S_LOAD: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        S_STEP: begin
`ifdef VLINE_ACCEL_EN
          if (dbl_q) begin
            state_q <= S_STEP2;
            up_q    <= step_up_q && !up2_block_c;
            dw_q    <= !step_up_q && !dw2_block_c;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
`else
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
`endif
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.UP     = up_q;
  assign bus.DW     = dw_q;
  assign bus.LD     = ld_q;
  assign bus.D      = d_q;
  assign bus.dir_up = dir_up_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_vline_motion_ctrl.sv
// Directed plus randomized bench for vline_motion_ctrl against a transaction-level model.
// Honours VLINE_ACCEL_EN when the design is built with it.
module tb_vline_motion_ctrl;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned TOP      = 487;
  localparam int unsigned BOT      = 18;
  localparam int unsigned START    = 240;
  localparam int unsigned STEP_DIV = 2;
  localparam int unsigned ACCEL    = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vline_motion_ctrl_if #(.WIDTH(WIDTH)) bus ();

  vline_motion_ctrl #(
    .WIDTH       (WIDTH),
    .TOP_LIMIT   (TOP),
    .BOT_LIMIT   (BOT),
    .START_POS   (START),
`ifdef VLINE_ACCEL_EN
    .ACCEL_STEPS (ACCEL),
`endif
    .STEP_DIV    (STEP_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int tick_cnt = 0;
  int nu, nd, nl, ru, mu, tu, td, tl, tr, tm;
  int ylist[12] = '{0, 17, 18, 19, 20, 240, 485, 486, 487, 488, 1000, 300};

  // Model state
  bit dir_m;
  int acc_m;
  bit acc_dir_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    tick_cnt++;
  endtask

  function automatic bit next_qual();
    return (tick_cnt % STEP_DIV) == (STEP_DIV - 1);
  endfunction

  function automatic int clampv(input int v);
    if (v < int'(BOT)) return int'(BOT);
    if (v > int'(TOP)) return int'(TOP);
    return v;
  endfunction

  task automatic observe(input int n, output int o_u, output int o_d, output int o_l,
                         output int o_r, output int o_m);
    bit pu;
    o_u = 0; o_d = 0; o_l = 0; o_r = 0; o_m = 0; pu = 1'b0;
    for (int i = 0; i < n; i++) begin
      o_u += int'(bus.UP);
      o_d += int'(bus.DW);
      o_l += int'(bus.LD);
      if (bus.UP && !pu) o_r++;
      pu = bus.UP;
      if ((int'(bus.UP) + int'(bus.DW) + int'(bus.LD)) > 1) o_m++;
      cyc();
    end
  endtask

  // One qualified tick followed by an observation window
  task automatic qstep(output int o_u, output int o_d, output int o_l, output int o_r,
                       output int o_m);
    if (!next_qual()) tick();
    tick();
    observe(4, o_u, o_d, o_l, o_r, o_m);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_dw     = 1'b0;
    bus.auto_en    = 1'b0;
    bus.load_req   = 1'b0;
    bus.load_val   = '0;
    bus.ycoord     = 16'd240;

    // Reset values
    reset = 1'b1;
    repeat (3) cyc();
    check("rst_up", bus.UP, 0);
    check("rst_dw", bus.DW, 0);
    check("rst_ld", bus.LD, 0);
    check("rst_d", bus.D, 0);
    check("rst_dir", bus.dir_up, 1);
    check("rst_busy", bus.busy, 1);

    // Initial load of the start position
    reset = 1'b0;
    cyc();
    check("init_ld", bus.LD, 1);
    check("init_d", bus.D, START);
    cyc();
    check("init_ld_once", bus.LD, 0);
    check("init_idle_busy", bus.busy, 0);

    // Held up button, four frame ticks -> two single-cycle UP pulses
    bus.btn_up = 1'b1;
    bus.ycoord = 16'd300;
    tu = 0; td = 0; tl = 0; tr = 0; tm = 0;
    repeat (4) begin
      tick();
      observe(3, nu, nd, nl, ru, mu);
      tu += nu; td += nd; tl += nl; tr += ru; tm += mu;
    end
    check("div_up_cnt", tu, 2);
    check("div_up_pulses", tr, 2);
    check("div_dw_cnt", td, 0);
    check("div_ld_cnt", tl, 0);
    check("div_excl", tm, 0);

    // Limits suppress strobes; manual steps leave dir_up alone
    bus.ycoord = 16'd487;
    qstep(nu, nd, nl, ru, mu);
    check("top_no_up", nu, 0);
    bus.btn_up = 1'b0;
    bus.btn_dw = 1'b1;
    bus.ycoord = 16'd18;
    qstep(nu, nd, nl, ru, mu);
    check("bot_no_dw", nd, 0);
    check("manual_dir", bus.dir_up, 1);

    // Auto bounce at the top
    bus.btn_dw  = 1'b0;
    bus.auto_en = 1'b1;
    bus.ycoord  = 16'd486;
    qstep(nu, nd, nl, ru, mu);
    check("auto_up", nu, 1);
    check("auto_dir_flip", bus.dir_up, 0);
    bus.ycoord = 16'd487;
    qstep(nu, nd, nl, ru, mu);
    check("auto_dw", nd, 1);
    check("auto_dw_no_up", nu, 0);
    bus.auto_en = 1'b0;

    // Load requested during STEP is deferred and clamped high
    bus.btn_up = 1'b1;
    bus.ycoord = 16'd300;
    if (!next_qual()) tick();
    tick();
    check("step_up_strobe", bus.UP, 1);
    check("step_busy", bus.busy, 1);
    bus.load_val = 16'd1000;
    bus.load_req = 1'b1;
    cyc();
    bus.load_req = 1'b0;
    observe(4, nu, nd, nl, ru, mu);
    check("pend_ld_cnt", nl, 1);
    check("pend_ld_d", bus.D, TOP);
    bus.load_val = 16'd5;
    bus.load_req = 1'b1;
    cyc();
    bus.load_req = 1'b0;
    observe(4, nu, nd, nl, ru, mu);
    check("low_ld_cnt", nl, 1);
    check("low_ld_d", bus.D, BOT);

    // Both buttons high is no request
    bus.btn_dw = 1'b1;
    tu = 0; td = 0; tl = 0;
    repeat (3) begin
      qstep(nu, nd, nl, ru, mu);
      tu += nu; td += nd; tl += nl;
    end
    check("both_btn_none", tu + td + tl, 0);

    // Long hold: doubled strobe on the ninth step only with acceleration
    bus.btn_dw = 1'b0;
    bus.ycoord = 16'd100;
    tu = 0; tr = 0;
    repeat (9) begin
      qstep(nu, nd, nl, ru, mu);
      tu += nu; tr += ru;
    end
`ifdef VLINE_ACCEL_EN
    check("hold_up_cnt", tu, 10);
`else
    check("hold_up_cnt", tu, 9);
`endif
    check("hold_up_steps", tr, 9);

    // Reset mid-operation discards a pending load
    bus.btn_up = 1'b0;
    cyc();
    bus.auto_en = 1'b1;
    bus.ycoord  = 16'd300;
    if (!next_qual()) tick();
    tick();
    check("auto_dw_step", bus.DW, 1);
    bus.load_val = 16'd400;
    bus.load_req = 1'b1;
    cyc();
    bus.load_req = 1'b0;
    bus.auto_en  = 1'b0;
    reset = 1'b1;
    cyc();
    tick_cnt = 0;
    check("mid_rst_ld", bus.LD, 0);
    check("mid_rst_dw", bus.DW, 0);
    check("mid_rst_d", bus.D, 0);
    check("mid_rst_dir", bus.dir_up, 1);
    reset = 1'b0;
    cyc();
    check("mid_init_ld", bus.LD, 1);
    check("mid_init_d", bus.D, START);
    cyc();
    observe(5, nu, nd, nl, ru, mu);
    check("mid_no_pending", nl, 0);
    check("mid_d_kept", bus.D, START);

    // Randomized transactions against the model
    dir_m = 1'b1;
    acc_m = 0;
    acc_dir_m = 1'b0;
    for (int k = 0; k < 120; k++) begin
      int kind, lv, y, eu, ed;
      bit bu, bd, ae, man, q, d, ok;
      kind = int'($urandom_range(0, 4));
      if (kind == 0) begin
        lv = int'($urandom_range(0, 1200));
        bus.load_val = 16'(lv);
        bus.load_req = 1'b1;
        cyc();
        bus.load_req = 1'b0;
        observe(4, nu, nd, nl, ru, mu);
        check("rnd_ld_cnt", nl, 1);
        check("rnd_ld_d", bus.D, clampv(lv));
        check("rnd_ld_nostep", nu + nd, 0);
        acc_m = 0;
      end else begin
        bu = 1'($urandom_range(0, 1));
        bd = 1'($urandom_range(0, 1));
        ae = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) y = ylist[$urandom_range(0, 11)];
        else y = int'($urandom_range(0, 600));
        bus.btn_up  = bu;
        bus.btn_dw  = bd;
        bus.auto_en = ae;
        bus.ycoord  = 16'(y);
        man = bu ^ bd;
        if (!man) acc_m = 0;
        q = next_qual();
        tick();
        observe(5, nu, nd, nl, ru, mu);
        eu = 0; ed = 0;
        if (q && (man || ae)) begin
          d  = man ? bu : dir_m;
          ok = d ? (y < int'(TOP)) : (y > int'(BOT));
          if (ok) begin
            if (d) eu = 1;
            else   ed = 1;
          end
          if (!man) begin
            if (d && (!ok || y == int'(TOP) - 1)) dir_m = 1'b0;
            if (!d && (!ok || y == int'(BOT) + 1)) dir_m = 1'b1;
          end
`ifdef VLINE_ACCEL_EN
          if (man) begin
            bit dbl, same;
            same = (acc_m > 0) && (acc_dir_m == bu);
            dbl  = same && (acc_m >= int'(ACCEL));
            acc_m = same ? ((acc_m < int'(ACCEL)) ? acc_m + 1 : acc_m) : 1;
            acc_dir_m = bu;
            if (dbl && d && (y + eu < int'(TOP))) eu++;
            if (dbl && !d && (y > int'(BOT) + ed)) ed++;
          end
`endif
        end
        check("rnd_up", nu, eu);
        check("rnd_dw", nd, ed);
        check("rnd_no_ld", nl, 0);
        check("rnd_dir", bus.dir_up, dir_m);
        check("rnd_excl", mu, 0);
        check("rnd_idle", bus.busy, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
